// File: rtl/alu_cmd_issue_if.sv
// Bundle of the command, ALU and result channels of alu_cmd_issue.
// slave  : the issue stage itself (accepts commands, drives the ALU, offers results).
// master : its surroundings (command source, the combinational ALU, result sink).
interface alu_cmd_issue_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_sel;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_use_acc;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_sel;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_carry;
    logic              res_div0;

    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc,
        output alu_out, alu_carry, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel,
        input  res_valid, res_data, res_carry, res_div0, fifo_count
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc,
        input  alu_out, alu_carry, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel,
        output res_valid, res_data, res_carry, res_div0, fifo_count
    );
endinterface

// File: rtl/alu_cmd_issue.sv
// Command-issue stage in front of an 8-bit combinational ALU.
// Commands {sel, a, b, use_acc} are queued in a small FIFO, issued one at a
// time into registered ALU inputs, and the ALU result/carry is captured into a
// result register offered on a valid/ready port. An accumulator holding the
// previous result can stand in for operand A to chain operations.
// Optional feature: define ALU_DIV0_CHECK_EN to flag divide-by-zero (sel 0011,
// B == 0) with res_div0 and force the result/accumulator to all ones.
module alu_cmd_issue #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_cmd_issue_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [3:0]        sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              use_acc;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    cmd_t              head;

    // A full FIFO refuses commands even when a pop frees a slot this cycle,
    // so cmd_ready depends only on registered state.
    assign push           = bus.cmd_valid && !full;
    assign fifo_empty     = (count == '0);
    assign head           = fifo_mem[rd_ptr];
    assign bus.cmd_ready  = !full;
    assign bus.fifo_count = count;

    // Write accepted commands into the storage array.
    // NOTE: the storage array is deliberately not reset; the pointers and count
    // define which entries are meaningful, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b,
                                  use_acc: bus.cmd_use_acc};
        end
    end

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // Pointer, count and registered-full bookkeeping; pointers wrap because
    // FIFO_DEPTH is a power of two.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   capture;
    logic   res_clear;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus pop/capture/clear strobes; a result handshake in DONE
    // may pop the next head in the same cycle to keep one result per 2 cycles.
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        res_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_clear = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue registers, accumulator and result register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [3:0]        alu_sel_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] res_data_q;
    logic              res_carry_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] cap_data;

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;

    // Load the ALU operands on issue; they hold between issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
        end else if (pop) begin
            alu_a_q   <= head.use_acc ? acc : head.a;
            alu_b_q   <= head.b;
            alu_sel_q <= head.sel;
        end
    end

`ifdef ALU_DIV0_CHECK_EN
    logic cap_div0;
    logic res_div0_q;

    // Replace a divide by zero with an all-ones result and raise the flag.
    always_comb begin
        cap_data = bus.alu_out;
        cap_div0 = 1'b0;
        if (alu_sel_q == 4'b0011 && alu_b_q == '0) begin
            cap_data = '1;
            cap_div0 = 1'b1;
        end
    end

    // Divide-by-zero flag travels with the captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_div0_q <= 1'b0;
        end else if (capture) begin
            res_div0_q <= cap_div0;
        end
    end

    assign bus.res_div0 = res_div0_q;
`else
    assign cap_data     = bus.alu_out;
    assign bus.res_div0 = 1'b0;
`endif

    // Capture the settled ALU output in EXEC; the accumulator changes only
    // here, so a chained command always sees the previous command's result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_valid_q <= 1'b0;
            acc         <= '0;
        end else if (capture) begin
            res_data_q  <= cap_data;
            res_carry_q <= bus.alu_carry;
            res_valid_q <= 1'b1;
            acc         <= cap_data;
        end else if (res_clear) begin
            res_valid_q <= 1'b0;
        end
    end

endmodule
